// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder.
// State and operation encodings plus word geometry.
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        ESPERA,
        RESP
    } estado_t;

    typedef enum logic [1:0] {
        OP_LEER,
        OP_ESCR,
        OP_ERR
    } op_t;

    // Classify a captured request; conflicting or misaligned ones become errors.
    function automatic op_t decodeOp(
        input logic       leer,
        input logic       escr,
        input logic [1:0] lsb
    );
        if ((leer && escr) || (lsb != 2'b00)) begin
            return OP_ERR;
        end else if (leer) begin
            return OP_LEER;
        end else begin
            return OP_ESCR;
        end
    endfunction

endpackage

// File: rtl/mem_datos_resp_if.sv
// Load/store bus between the core and the data-memory responder.
// The core is the master; the responder is the slave.
interface mem_datos_resp_if;
    import mem_pkg::*;

    logic              LeerMem;
    logic              EscrMem;
    logic [31:0]       Direccion;
    logic [WORD_W-1:0] DatoEscr;
    logic [BE_W-1:0]   ByteEn;
    logic [WORD_W-1:0] DatoLeido;
    logic              Listo;
    logic              Err;
    logic              Ocupado;

    modport master (
        output LeerMem, EscrMem, Direccion, DatoEscr, ByteEn,
        input  DatoLeido, Listo, Err, Ocupado
    );

    modport slave (
        input  LeerMem, EscrMem, Direccion, DatoEscr, ByteEn,
        output DatoLeido, Listo, Err, Ocupado
    );

endinterface

// File: rtl/mem_array_be.sv
// Single-port word RAM with per-byte write enables.
// The read register only changes when a read is performed.
module mem_array_be
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wrData,
    input  logic [BE_W-1:0]   byteEn,
    output logic [WORD_W-1:0] rdData
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    // Byte-masked write; the array itself has no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (byteEn[i]) begin
                    mem[addr][8*i +: 8] <= wrData[8*i +: 8];
                end
            end
        end
    end

    // Registered read that holds its value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdData <= '0;
        end else if (re) begin
            rdData <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_datos_resp.sv
// Multi-cycle data-memory responder with configurable wait states.
// One request in flight; Listo/Err pulse one cycle when it completes.
module mem_datos_resp
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LAT    = 2
) (
    input  logic             CLK,
    input  logic             Reset,
    mem_datos_resp_if.slave  bus
);

    localparam logic [3:0] LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    estado_t           state;
    op_t               opQ;
    logic [ADDR_W-1:0] addrQ;
    logic [WORD_W-1:0] datoQ;
    logic [BE_W-1:0]   beQ;
    logic [3:0]        cnt;
    logic              listoQ;
    logic              errQ;
    logic              ocupQ;
    logic              req;
    logic              arrWe;
    logic              arrRe;
    logic [WORD_W-1:0] rdData;
    logic              unusedAddr;

    // The acknowledge cycle itself never accepts a request, so a
    // requester dropping its strobe on the Listo edge is not re-served.
    assign req = (bus.LeerMem | bus.EscrMem) & ~listoQ;

    // The array is touched only on the edge that completes the access.
    assign arrWe = (state == RESP) && (opQ == OP_ESCR);
    assign arrRe = (state == RESP) && (opQ == OP_LEER);

    assign unusedAddr = ^{bus.Direccion[31:ADDR_W+2]};

    // Request capture, wait-state countdown and registered handshake outputs.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            cnt    <= '0;
            opQ    <= OP_LEER;
            addrQ  <= '0;
            datoQ  <= '0;
            beQ    <= '0;
            listoQ <= 1'b0;
            errQ   <= 1'b0;
            ocupQ  <= 1'b0;
        end else begin
            listoQ <= 1'b0;
            errQ   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        opQ   <= decodeOp(bus.LeerMem, bus.EscrMem,
                                          bus.Direccion[1:0]);
                        addrQ <= bus.Direccion[ADDR_W+1:2];
                        datoQ <= bus.DatoEscr;
                        beQ   <= bus.ByteEn;
                        ocupQ <= 1'b1;
                        if (LAT > 0) begin
                            state <= ESPERA;
                            cnt   <= LAT_M1;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                ESPERA: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    listoQ <= 1'b1;
                    errQ   <= (opQ == OP_ERR);
                    ocupQ  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_array_be #(
        .ADDR_W (ADDR_W)
    ) uArray (
        .clk    (CLK),
        .rst    (Reset),
        .we     (arrWe),
        .re     (arrRe),
        .addr   (addrQ),
        .wrData (datoQ),
        .byteEn (beQ),
        .rdData (rdData)
    );

    assign bus.DatoLeido = rdData;
    assign bus.Listo     = listoQ;
    assign bus.Err       = errQ;
    assign bus.Ocupado   = ocupQ;

endmodule

// File: tb/tb_mem_datos_resp.sv
// Bench for mem_datos_resp: four instances at LAT 2, 0, 3 and 1.
// Expected responses come from a byte-level memory model and a queue.
module tb_mem_datos_resp;

    typedef struct {
        logic [31:0] dato;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [1:0]  s;
        logic        l;
        logic        e;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sel = 2'd0;
    logic        leer = 1'b0;
    logic        escr = 1'b0;
    logic [31:0] dir = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  be = '0;

    logic [3:0]  listoV;
    logic [3:0]  errV;
    logic [3:0]  ocupV;
    logic [31:0] datoV [4];
    logic        listo;
    logic        err;
    logic        ocup;
    logic [31:0] dato;

    int          latV [4] = '{2, 0, 3, 1};
    logic [31:0] model [4][256];
    logic [31:0] lastRd [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    exp_t        sbq [$];

    int          total = 0;
    int          bad = 0;

    int          obsLat;
    logic        obsErr;
    logic        obsBusy0;
    logic        obsBusyEnd;
    logic [31:0] obsDato;

    always #5 clk = ~clk;

    mem_datos_resp_if bus [4] ();

    for (genvar k = 0; k < 4; k++) begin : g_dut
        assign bus[k].LeerMem   = leer && (sel == 2'(k));
        assign bus[k].EscrMem   = escr && (sel == 2'(k));
        assign bus[k].Direccion = dir;
        assign bus[k].DatoEscr  = wdat;
        assign bus[k].ByteEn    = be;
        assign listoV[k]        = bus[k].Listo;
        assign errV[k]          = bus[k].Err;
        assign ocupV[k]         = bus[k].Ocupado;
        assign datoV[k]         = bus[k].DatoLeido;

        mem_datos_resp #(
            .ADDR_W (8),
            .LAT    ((k == 0) ? 2 : (k == 1) ? 0 : (k == 2) ? 3 : 1)
        ) u_dut (
            .CLK   (clk),
            .Reset (rst),
            .bus   (bus[k])
        );
    end

    assign listo = listoV[sel];
    assign err   = errV[sel];
    assign ocup  = ocupV[sel];
    assign dato  = datoV[sel];

    task automatic issue(input logic [1:0] s, input logic l, input logic e,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b);
        exp_t x;
        logic isErr;
        int   w;
        isErr = (l && e) || (a[1:0] != 2'b00);
        w = int'(a[9:2]);
        if (!isErr && e) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) model[s][w][8*i +: 8] = d[8*i +: 8];
            end
        end
        if (!isErr && l) lastRd[s] = model[s][w];
        x.dato = lastRd[s];
        x.err  = isErr;
        x.lat  = latV[s] + 1;
        sbq.push_back(x);
        @(posedge clk); #1;
        sel = s; leer = l; escr = e; dir = a; wdat = d; be = b;
    endtask

    task automatic waitResp();
        int n;
        n = 0;
        @(posedge clk); #1;
        obsBusy0 = ocup;
        while (listo !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        obsLat = n;
        obsErr = err;
        obsDato = dato;
        obsBusyEnd = ocup;
        leer = 1'b0;
        escr = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] orv;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        orv = datoV[0] | datoV[1] | datoV[2] | datoV[3];
        total++;
        if (listoV !== 4'h0 || errV !== 4'h0 || ocupV !== 4'h0 || orv !== 32'h0) begin
            bad++;
            $display("FAIL reset: listo=%b err=%b ocup=%b dato|=%h, want all 0",
                     listoV, errV, ocupV, orv);
        end
        rst = 1'b0;
    endtask

    task automatic test_lat2();
        req_t t [2];
        exp_t x;
        t = '{'{2'd0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF},
              '{2'd0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0}};
        foreach (t[i]) begin
            issue(t[i].s, t[i].l, t[i].e, t[i].a, t[i].d, t[i].b);
            waitResp();
            x = sbq.pop_front();
            total++;
            if (obsLat !== x.lat || obsErr !== x.err || obsDato !== x.dato) begin
                bad++;
                $display("FAIL lat2[%0d]: lat=%0d err=%b dato=%h, want lat=%0d err=%b dato=%h",
                         i, obsLat, obsErr, obsDato, x.lat, x.err, x.dato);
            end
            total++;
            if (obsBusy0 !== 1'b1 || obsBusyEnd !== 1'b0) begin
                bad++;
                $display("FAIL lat2_busy[%0d]: ocup during=%b at listo=%b, want 1 and 0",
                         i, obsBusy0, obsBusyEnd);
            end
        end
        @(posedge clk); #1;
        total++;
        if (listo !== 1'b0) begin
            bad++;
            $display("FAIL lat2_pulse: listo=%b one cycle later, want 0", listo);
        end
    endtask

    task automatic test_lat0();
        req_t t [5];
        exp_t x;
        t = '{'{2'd1, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF},
              '{2'd1, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5},
              '{2'd1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0},
              '{2'd1, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0},
              '{2'd1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0}};
        foreach (t[i]) begin
            issue(t[i].s, t[i].l, t[i].e, t[i].a, t[i].d, t[i].b);
            waitResp();
            x = sbq.pop_front();
            total++;
            if (obsLat !== x.lat || obsErr !== x.err || obsDato !== x.dato) begin
                bad++;
                $display("FAIL lat0[%0d]: lat=%0d err=%b dato=%h, want lat=%0d err=%b dato=%h",
                         i, obsLat, obsErr, obsDato, x.lat, x.err, x.dato);
            end
        end
    endtask

    task automatic test_err();
        req_t t [4];
        exp_t x;
        t = '{'{2'd1, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF},
              '{2'd1, 1'b1, 1'b0, 32'h22, 32'h0, 4'h0},
              '{2'd1, 1'b1, 1'b1, 32'h30, 32'h01020304, 4'hF},
              '{2'd1, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0}};
        foreach (t[i]) begin
            issue(t[i].s, t[i].l, t[i].e, t[i].a, t[i].d, t[i].b);
            waitResp();
            x = sbq.pop_front();
            total++;
            if (obsLat !== x.lat || obsErr !== x.err || obsDato !== x.dato) begin
                bad++;
                $display("FAIL err[%0d]: lat=%0d err=%b dato=%h, want lat=%0d err=%b dato=%h",
                         i, obsLat, obsErr, obsDato, x.lat, x.err, x.dato);
            end
        end
    endtask

    task automatic test_wrap();
        req_t t [2];
        exp_t x;
        t = '{'{2'd0, 1'b0, 1'b1, 32'h404, 32'h5A5A5A5A, 4'hF},
              '{2'd0, 1'b1, 1'b0, 32'h004, 32'h0, 4'h0}};
        foreach (t[i]) begin
            issue(t[i].s, t[i].l, t[i].e, t[i].a, t[i].d, t[i].b);
            waitResp();
            x = sbq.pop_front();
            total++;
            if (obsLat !== x.lat || obsErr !== x.err || obsDato !== x.dato) begin
                bad++;
                $display("FAIL wrap[%0d]: lat=%0d err=%b dato=%h, want lat=%0d err=%b dato=%h",
                         i, obsLat, obsErr, obsDato, x.lat, x.err, x.dato);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t x;
        logic [31:0] orv;
        logic sawL;
        issue(2'd2, 1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF);
        waitResp();
        x = sbq.pop_front();
        total++;
        if (obsLat !== x.lat || obsErr !== x.err || obsDato !== x.dato) begin
            bad++;
            $display("FAIL rstmid_pre: lat=%0d err=%b dato=%h, want lat=%0d err=%b dato=%h",
                     obsLat, obsErr, obsDato, x.lat, x.err, x.dato);
        end
        @(posedge clk); #1;
        sel = 2'd2; leer = 1'b0; escr = 1'b1;
        dir = 32'h40; wdat = 32'hFFFFFFFF; be = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (ocup !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_busy: ocup=%b, want 1", ocup);
        end
        rst = 1'b1;
        #2;
        orv = datoV[0] | datoV[1] | datoV[2] | datoV[3];
        total++;
        if (listoV !== 4'h0 || errV !== 4'h0 || ocupV !== 4'h0 || orv !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_outs: listo=%b err=%b ocup=%b dato|=%h, want all 0",
                     listoV, errV, ocupV, orv);
        end
        rst = 1'b0;
        escr = 1'b0;
        for (int k = 0; k < 4; k++) lastRd[k] = 32'h0;
        sawL = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            sawL = sawL | (listoV != 4'h0);
        end
        total++;
        if (sawL !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_nolisto: listo seen=%b, want 0", sawL);
        end
        issue(2'd2, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        waitResp();
        x = sbq.pop_front();
        total++;
        if (obsLat !== x.lat || obsErr !== x.err || obsDato !== x.dato) begin
            bad++;
            $display("FAIL rstmid_read: lat=%0d err=%b dato=%h, want lat=%0d err=%b dato=%h",
                     obsLat, obsErr, obsDato, x.lat, x.err, x.dato);
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        int   n;
        logic width;
        logic sawL;
        issue(2'd3, 1'b0, 1'b1, 32'h8, 32'h0BADC0DE, 4'hF);
        waitResp();
        x = sbq.pop_front();
        total++;
        if (obsLat !== x.lat || obsErr !== x.err || obsDato !== x.dato) begin
            bad++;
            $display("FAIL b2b_wr: lat=%0d err=%b dato=%h, want lat=%0d err=%b dato=%h",
                     obsLat, obsErr, obsDato, x.lat, x.err, x.dato);
        end
        issue(2'd3, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        sbq.push_back(sbq[$]);
        n = 0;
        @(posedge clk); #1;
        while (listo !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        x = sbq.pop_front();
        total++;
        if (n !== x.lat || err !== x.err || dato !== x.dato) begin
            bad++;
            $display("FAIL b2b_first: lat=%0d err=%b dato=%h, want lat=%0d err=%b dato=%h",
                     n, err, dato, x.lat, x.err, x.dato);
        end
        n = 1;
        @(posedge clk); #1;
        width = listo;
        while (listo !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        x = sbq.pop_front();
        total++;
        if (n !== x.lat + 2 || err !== x.err || dato !== x.dato) begin
            bad++;
            $display("FAIL b2b_second: spacing=%0d err=%b dato=%h, want spacing=%0d err=%b dato=%h",
                     n, err, dato, x.lat + 2, x.err, x.dato);
        end
        leer = 1'b0;
        total++;
        if (width !== 1'b0) begin
            bad++;
            $display("FAIL b2b_width: listo after pulse=%b, want 0", width);
        end
        sawL = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            sawL = sawL | listo;
        end
        total++;
        if (sawL !== 1'b0) begin
            bad++;
            $display("FAIL b2b_extra: extra listo=%b, want 0", sawL);
        end
    endtask

    initial begin
        test_reset();
        test_lat2();
        test_lat0();
        test_err();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
